multicycle_controller: RTL

//  Multicycle ARM control FSM; sequences shared PC/IR/ALU/memory datapath per instruction.

---
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle ARM-subset datapath. It sequences the shared
//   PC / IR / ALU / memory datapath one instruction at a time. It also owns the
//   NZCV flag register and the condition check done against those flags.
//   Instructions: ADD/SUB/AND/ORR (register or immediate), LDR/STR with an
//   immediate offset, and B.
//   Every control output is decoded from the registered state. Write strobes
//   and the flag update are forced low while reset is high.
//
// Optional feature: define CMP_INSTR_EN to enable CMP (funct[4:1]=1010).
//   CMP performs a SUB, always writes the flags, and has no register writeback.
//   When CMP_INSTR_EN is undefined, 1010 is treated like any other
//   unsupported opcode.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cond/op/funct/rd      instruction fields Instr[31:28]/[27:26]/[25:20]/[15:12]
//   alu_flags             NZCV produced by the ALU in the current cycle
//   pc_write, ir_write,
//   mem_write, reg_write  write strobes
//   adr_src               memory address: 0=PC, 1=ALU result
//   result_src            00=ALUOut reg, 01=data reg, 10=ALU result
//   alu_src_a             0=RD1 reg, 1=PC
//   alu_src_b             00=RD2 reg, 01=ExtImm, 10=constant 4
//   alu_control           00 ADD, 01 SUB, 10 AND, 11 ORR
//   imm_src               00 DP imm8, 01 memory imm12, 10 branch imm24
//   reg_src               [0]=1 selects RA1=PC, [1]=1 selects RA2=rd
//   flags                 stored NZCV {n,z,c,v}
//   dbg_state             current FSM state (debug observation)
module multicycle_controller #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter logic [3:0] PC_REG      = 4'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
   output logic       pc_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_control,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [3:0] flags,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_t;

   state_t     state, state_next;
   logic       cond_ex;
   logic [1:0] dp_ctrl;
   logic       dp_ok, dp_cmp;
   logic       pc_raw, ir_raw, mem_raw, reg_raw, flag_raw;

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         flags <= RESET_FLAGS;
      end else begin
         state <= state_next;
         if (flag_raw) flags <= alu_flags;
      end
   end

   // Condition check against the stored flags {n,z,c,v}.
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flags[2];
         4'b0001: cond_ex = ~flags[2];
         4'b0010: cond_ex = flags[1];
         4'b0011: cond_ex = ~flags[1];
         4'b0100: cond_ex = flags[3];
         4'b0101: cond_ex = ~flags[3];
         4'b0110: cond_ex = flags[0];
         4'b0111: cond_ex = ~flags[0];
         4'b1000: cond_ex = flags[1] & ~flags[2];
         4'b1001: cond_ex = ~flags[1] | flags[2];
         4'b1010: cond_ex = (flags[3] == flags[0]);
         4'b1011: cond_ex = (flags[3] != flags[0]);
         4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Data-processing opcode decode. When dp_ok=0 there is no writeback, and
   // the flags are written only for supported opcodes (and CMP).
   always_comb begin
      dp_ctrl = 2'b00;
      dp_ok   = 1'b0;
      dp_cmp  = 1'b0;
      case (funct[4:1])
         4'b0100: begin dp_ctrl = 2'b00; dp_ok = 1'b1; end
         4'b0010: begin dp_ctrl = 2'b01; dp_ok = 1'b1; end
         4'b0000: begin dp_ctrl = 2'b10; dp_ok = 1'b1; end
         4'b1100: begin dp_ctrl = 2'b11; dp_ok = 1'b1; end
`ifdef CMP_INSTR_EN
         4'b1010: begin dp_ctrl = 2'b01; dp_cmp = 1'b1; end
`endif
         default: dp_ctrl = 2'b00;
      endcase
   end

   always_comb begin
      state_next  = S_FETCH;
      pc_raw      = 1'b0;
      ir_raw      = 1'b0;
      mem_raw     = 1'b0;
      reg_raw     = 1'b0;
      flag_raw    = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 2'b00;
      imm_src     = 2'b00;
      reg_src     = 2'b00;
      case (state)
         S_FETCH: begin
            ir_raw     = 1'b1;
            pc_raw     = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            // The ALU computes PC+8 here so that it is available as R15.
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (!cond_ex || op == 2'b11) state_next = S_FETCH;
            else if (op == 2'b01)        state_next = S_MEMADR;
            else if (op == 2'b10)        state_next = S_BRANCH;
            else if (funct[5])           state_next = S_EXECI;
            else                         state_next = S_EXECR;
         end
         S_EXECR, S_EXECI: begin
            alu_src_b   = (state == S_EXECI) ? 2'b01 : 2'b00;
            alu_control = dp_ctrl;
            flag_raw    = (dp_ok & funct[0]) | dp_cmp;
            state_next  = (dp_ok && !dp_cmp) ? S_ALUWB : S_FETCH;
         end
         S_ALUWB: begin
            if (rd == PC_REG) pc_raw = 1'b1;
            else              reg_raw = 1'b1;
         end
         S_MEMADR: begin
            alu_src_b  = 2'b01;
            imm_src    = 2'b01;
            state_next = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_src    = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            if (rd == PC_REG) pc_raw = 1'b1;
            else              reg_raw = 1'b1;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_raw = 1'b1;
            reg_src = 2'b10;
         end
         S_BRANCH: begin
            reg_src    = 2'b01;
            alu_src_b  = 2'b01;
            imm_src    = 2'b10;
            result_src = 2'b10;
            pc_raw     = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   assign pc_write  = pc_raw  & ~reset;
   assign ir_write  = ir_raw  & ~reset;
   assign mem_write = mem_raw & ~reset;
   assign reg_write = reg_raw & ~reset;

endmodule
